// File: rtl/therm_pkg.sv
// Shared types and constants for the thermometer word generator.
// Holds the FSM state enum, default sizes and the count-width helper.
package therm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUILD = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int WIDTH_DEF     = 16;
    localparam int NUM_WORDS_DEF = 9;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/therm_shifter.sv
// Thermometer shift register plus remaining-ones down-counter.
// Ports: clk, rst, load/load_count (clear + arm), shift, shreg, done.
module therm_shifter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_count,
    input  logic             shift,
    output logic [WIDTH-1:0] shreg,
    output logic             done
);

    logic [CNT_W-1:0] remaining;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg     <= '0;
            remaining <= '0;
        end else if (load) begin
            shreg     <= '0;
            remaining <= load_count;
        end else if (shift && remaining != '0) begin
            shreg     <= {shreg[WIDTH-2:0], 1'b1};
            remaining <= remaining - CNT_W'(1);
        end
    end

    // High when the shift taken at the next edge is the final one,
    // so the FSM can enter HOLD on that same edge.
    assign done = (remaining == CNT_W'(1));

endmodule

// File: rtl/therm_word_gen.sv
// Sequential thermometer word generator with framed valid/ready output.
// Ports: clk, rst, in_count/in_valid/in_ready, frame_clr,
//        out_data/out_valid/out_ready, out_last, out_sat.
module therm_word_gen
    import therm_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int NUM_WORDS = NUM_WORDS_DEF,
    parameter int CNT_W     = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] in_count,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             frame_clr,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             out_sat
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic             sat_q;
    logic [IDX_W-1:0] word_idx;
    logic             accept;
    logic             over;
    logic [CNT_W-1:0] n_clamp;
    logic [WIDTH-1:0] shreg;
    logic             shift_done;

    assign accept  = (state == IDLE) && in_valid;
    assign over    = (in_count > CNT_MAX);
    assign n_clamp = over ? CNT_MAX : in_count;

    therm_shifter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .load_count (n_clamp),
        .shift      (state == BUILD),
        .shreg      (shreg),
        .done       (shift_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (in_valid)
                    state_nxt = (n_clamp == '0) ? HOLD : BUILD;
            end
            BUILD: begin
                if (shift_done) state_nxt = HOLD;
            end
            HOLD: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == HOLD);
        out_data  = (state == HOLD) ? shreg : '0;
        out_sat   = (state == HOLD) && sat_q;
        out_last  = (state == HOLD) && (word_idx == LAST_IDX);
    end

    // frame_clr takes priority over the handshake increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q    <= 1'b0;
            word_idx <= '0;
        end else begin
            if (accept) sat_q <= over;
            if (frame_clr)
                word_idx <= '0;
            else if (state == HOLD && out_ready)
                word_idx <= (word_idx == LAST_IDX) ? '0
                                                   : word_idx + IDX_W'(1);
        end
    end

endmodule

// File: tb/tb_therm_word_gen.sv
// Randomized scoreboard bench for therm_word_gen.
// Driver pushes expected words; a negedge monitor pops and compares.
module tb_therm_word_gen;

    logic        clk;
    logic        rst;
    logic [4:0]  in_count;
    logic        in_valid;
    logic        in_ready;
    logic        frame_clr;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        out_sat;

    typedef struct {
        logic [15:0] data;
        logic        last;
        logic        sat;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   m_idx = 0;

    therm_word_gen dut (
        .clk       (clk),
        .rst       (rst),
        .in_count  (in_count),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .frame_clr (frame_clr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      nm, act, exp, $time);
    endtask

    // Monitor: one pop per output handshake.
    always @(negedge clk) begin
        #1;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("mon_queue_nonempty", sb.size(), 1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("mon_data", int'(out_data), int'(e.data));
                check("mon_last", int'(out_last), int'(e.last));
                check("mon_sat",  int'(out_sat),  int'(e.sat));
            end
        end
    end

    task automatic send(input int cnt, input int stall, input bit clr);
        int    n;
        int    w;
        int    k;
        int    bad;
        int    rdy;
        logic [31:0] ones;
        exp_t  e;
        n      = (cnt > 16) ? 16 : cnt;
        ones   = (32'd1 << n) - 32'd1;
        e.data = ones[15:0];
        e.sat  = (cnt > 16);
        e.last = (m_idx == 8);
        sb.push_back(e);

        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_wait", int'(in_ready), 1);
        in_count = 5'(cnt);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (stall > 0) out_ready = 1'b0;

        k = 0;
        @(negedge clk);
        while (!out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("latency", k, n);

        if (stall > 0) begin
            bad = 0;
            rdy = 0;
            for (int i = 0; i < stall; i++) begin
                if (!out_valid || out_data !== e.data) bad++;
                if (in_ready) rdy++;
                in_valid = 1'($urandom_range(0, 1));
                in_count = 5'($urandom);
                @(negedge clk);
            end
            check("hold_stable", bad, 0);
            check("in_ready_hold", rdy, 0);
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        frame_clr = clr;
        @(posedge clk);
        #1;
        frame_clr = 1'b0;
        m_idx = clr ? 0 : (m_idx + 1) % 9;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        int t1[9];
        t1 = '{5, 8, 4, 10, 14, 9, 6, 13, 3};
        rst       = 1'b1;
        in_count  = '0;
        in_valid  = 1'b0;
        frame_clr = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data",  int'(out_data),  0);
        check("rst_out_last",  int'(out_last),  0);
        check("rst_out_sat",   int'(out_sat),   0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);

        // Full frame, last on the 9th word, then wrap.
        foreach (t1[i]) send(t1[i], 0, 1'b0);
        // Extremes of the count range.
        send(0, 0, 1'b0);
        send(16, 0, 1'b0);
        // Saturation then a normal word.
        send(20, 0, 1'b0);
        send(2, 0, 1'b0);
        // Backpressure with ignored input pulses.
        send(7, 10, 1'b0);

        // Reset during BUILD of 12 after four shifts.
        @(negedge clk);
        in_count = 5'd12;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_data",  int'(out_data),  0);
        check("midrst_last",  int'(out_last),  0);
        check("midrst_sat",   int'(out_sat),   0);
        @(negedge clk);
        rst = 1'b0;
        m_idx = 0;
        send(3, 0, 1'b0);

        // frame_clr on the handshake of word index 4.
        send(1, 0, 1'b0);
        send(2, 1, 1'b0);
        send(15, 0, 1'b0);
        send(11, 2, 1'b1);
        for (int i = 0; i < 9; i++) send(i + 4, 0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 30; i++) begin
            send(int'($urandom_range(0, 31)),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0,
                 ($urandom_range(0, 9) == 0));
        end

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
